sb_tx_fsm: RTL and testbench

Sideband transmit controller, the TX-side peer of the sideband receive FSM. It emits the 64-bit sideband clock pattern during link bring-up, then frames header/data messages for the serializer. Control parity (CP) and data parity (DP) are inserted so the far-end receiver's parity checks pass. The block sits between the sideband message encoder/LTSM and the 64-bit sideband serializer.

---
 rtl/sb_pkg.sv | 24 ++
 rtl/sb_tx_parity_gen.sv | 17 +
 rtl/sb_tx_fsm.sv | 154 +++++++++++++++
 tb/tb_sb_tx_fsm.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared sideband definitions: TX state encoding, pattern word, LTSM and header field constants.
package sb_pkg;

   typedef enum logic [2:0] {
      TX_IDLE    = 3'd0,
      TX_PATTERN = 3'd1,
      TX_HDR     = 3'd2,
      TX_DATA    = 3'd3,
      TX_GAP     = 3'd4
   } tx_state_e;

   localparam logic [63:0] SB_PATTERN_WORD   = 64'hAAAA_AAAA_AAAA_AAAA;
   localparam logic [2:0]  LTSM_RESET        = 3'd0;
   localparam logic [4:0]  OPC_MSG_WITH_DATA = 5'b11011;
   localparam logic [4:0]  OPC_MSG_NO_DATA   = 5'b10010;

   localparam int HDR_CP_BIT      = 62;
   localparam int HDR_DP_BIT      = 63;
   localparam int HDR_DSTID_MSB   = 58;
   localparam int HDR_DSTID_LSB   = 56;
   localparam int HDR_MSGCODE_MSB = 21;
   localparam int HDR_MSGCODE_LSB = 18;

endpackage

// File: rtl/sb_tx_parity_gen.sv
// Combinational CP/DP generation for a sideband header; only built when SB_TX_PARITY_EN is defined.
module sb_tx_parity_gen
   import sb_pkg::*;
(
   input  logic [61:0] i_header,
   input  logic [63:0] i_data,
   input  logic        i_has_data,
   output logic [63:0] o_header
);

   always_comb begin
      o_header             = {2'b00, i_header};
      o_header[HDR_CP_BIT] = ^i_header;
      o_header[HDR_DP_BIT] = i_has_data ? ^i_data : 1'b0;
   end

endmodule

// File: rtl/sb_tx_fsm.sv
// Sideband TX controller: clock pattern burst during bring-up, then header/data framing with gap.
// Macro SB_TX_PARITY_EN inserts CP/DP into header bits 62/63; otherwise they pass through.
module sb_tx_fsm
   import sb_pkg::*;
#(
   parameter int PATTERN_ITER = 4,
   parameter int GAP_CYCLES   = 32
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [2:0]  i_state,
   input  logic        i_start_pattern_req,
   input  logic        i_pattern_stop,
   input  logic        i_msg_valid,
   input  logic [63:0] i_header,
   input  logic        i_has_data,
   input  logic [63:0] i_data,
   input  logic        i_ser_ready,
   output logic        o_ser_valid,
   output logic [63:0] o_ser_data,
   output logic        o_msg_ack,
   output logic        o_pattern_done,
   output logic        o_busy
);

   localparam logic [7:0] ITER_LAST = 8'(PATTERN_ITER - 1);
   localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

   tx_state_e   state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        stop_q, stop_d;
   logic [63:0] data_q, data_d;
   logic        has_data_q, has_data_d;
   logic        ser_valid_q, ser_valid_d;
   logic [63:0] ser_data_q, ser_data_d;
   logic        msg_ack_q, msg_ack_d;
   logic        pattern_done_q, pattern_done_d;
   logic        busy_q, busy_d;

   logic [63:0] hdr_word;
   logic        accept, ltsm_reset, pat_inc, pat_done, gap_done;

`ifdef SB_TX_PARITY_EN
   sb_tx_parity_gen u_parity (
      .i_header   (i_header[61:0]),
      .i_data     (i_data),
      .i_has_data (i_has_data),
      .o_header   (hdr_word)
   );
`else
   assign hdr_word = i_header;
`endif

   assign accept     = ser_valid_q & i_ser_ready;
   assign ltsm_reset = (i_state == LTSM_RESET);
   // A stop in the same cycle as an accepted word counts that word.
   assign pat_inc    = accept & (stop_q | i_pattern_stop);
   assign pat_done   = pat_inc & (cnt_q >= ITER_LAST);
   assign gap_done   = (cnt_q >= GAP_LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= TX_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         TX_IDLE: begin
            if (i_start_pattern_req && ltsm_reset) state_d = TX_PATTERN;
            else if (i_msg_valid && !ltsm_reset)   state_d = TX_HDR;
         end
         TX_PATTERN: if (pat_done) state_d = TX_GAP;
         TX_HDR: begin
            if (ltsm_reset)  state_d = TX_IDLE;
            else if (accept) state_d = has_data_q ? TX_DATA : TX_GAP;
         end
         TX_DATA: begin
            if (ltsm_reset)  state_d = TX_IDLE;
            else if (accept) state_d = TX_GAP;
         end
         TX_GAP:  if (gap_done) state_d = TX_IDLE;
         default: state_d = TX_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_comb begin
      cnt_d          = cnt_q;
      stop_d         = stop_q;
      data_d         = data_q;
      has_data_d     = has_data_q;
      ser_data_d     = ser_data_q;
      msg_ack_d      = 1'b0;
      pattern_done_d = 1'b0;
      unique case (state_q)
         TX_IDLE: begin
            if (i_start_pattern_req && ltsm_reset) begin
               cnt_d      = '0;
               stop_d     = 1'b0;
               ser_data_d = SB_PATTERN_WORD;
            end else if (i_msg_valid && !ltsm_reset) begin
               data_d     = i_data;
               has_data_d = i_has_data;
               msg_ack_d  = 1'b1;
               ser_data_d = hdr_word;
            end
         end
         TX_PATTERN: begin
            if (i_pattern_stop) stop_d = 1'b1;
            if (pat_inc && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            pattern_done_d = pat_done;
         end
         TX_HDR:  if (accept && has_data_q) ser_data_d = data_q;
         TX_GAP:  if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
         default: ;
      endcase
      if (state_d == TX_GAP && state_q != TX_GAP) cnt_d = '0;
      ser_valid_d = (state_d == TX_PATTERN) || (state_d == TX_HDR) || (state_d == TX_DATA);
      busy_d      = (state_d != TX_IDLE);
      if (!ser_valid_d) ser_data_d = '0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q          <= '0;
         stop_q         <= 1'b0;
         data_q         <= '0;
         has_data_q     <= 1'b0;
         ser_valid_q    <= 1'b0;
         ser_data_q     <= '0;
         msg_ack_q      <= 1'b0;
         pattern_done_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         stop_q         <= stop_d;
         data_q         <= data_d;
         has_data_q     <= has_data_d;
         ser_valid_q    <= ser_valid_d;
         ser_data_q     <= ser_data_d;
         msg_ack_q      <= msg_ack_d;
         pattern_done_q <= pattern_done_d;
         busy_q         <= busy_d;
      end
   end

   assign o_ser_valid    = ser_valid_q;
   assign o_ser_data     = ser_data_q;
   assign o_msg_ack      = msg_ack_q;
   assign o_pattern_done = pattern_done_q;
   assign o_busy         = busy_q;

endmodule

// File: tb/tb_sb_tx_fsm.sv
// Directed bench for sb_tx_fsm: expected word stream, hold-stability and pulse timing checks.
module tb_sb_tx_fsm;

   localparam int PI = 4;
   localparam int GC = 32;
`ifdef SB_TX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst, i_start_pattern_req, i_pattern_stop, i_msg_valid, i_has_data, i_ser_ready;
   logic [2:0]  i_state;
   logic [63:0] i_header, i_data;
   logic        o_ser_valid, o_msg_ack, o_pattern_done, o_busy;
   logic [63:0] o_ser_data;

   always #5 i_clk = ~i_clk;

   sb_tx_fsm #(.PATTERN_ITER(PI), .GAP_CYCLES(GC)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_state(i_state),
      .i_start_pattern_req(i_start_pattern_req), .i_pattern_stop(i_pattern_stop),
      .i_msg_valid(i_msg_valid), .i_header(i_header), .i_has_data(i_has_data),
      .i_data(i_data), .i_ser_ready(i_ser_ready), .o_ser_valid(o_ser_valid),
      .o_ser_data(o_ser_data), .o_msg_ack(o_msg_ack), .o_pattern_done(o_pattern_done),
      .o_busy(o_busy)
   );

   int          checks = 0, failures = 0;
   int          n_acc = 0, n_ack = 0, n_done = 0;
   logic [63:0] exp_q[$];
   logic        allow_drop = 1'b0;
   logic        prev_hold = 1'b0;
   logic [63:0] prev_data = '0;

   // Header word the far-end should see, straight from the framing rules.
   function automatic logic [63:0] exp_hdr(logic [63:0] h, logic [63:0] d, logic hd);
      logic [63:0] w;
      w = {(hd ? ^d : 1'b0), ^h[61:0], h[61:0]};
      return PAR_EN ? w : h;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Stream monitor: every accepted word must be the next expected one; held words must not move.
   always @(negedge i_clk) begin
      if (prev_hold) begin
         checks++;
         if (!(o_ser_valid === 1'b1 && o_ser_data === prev_data)) begin
            failures++;
            $display("FAIL hold_stable actual=%b/%h expected=1/%h", o_ser_valid, o_ser_data, prev_data);
         end
      end
      if (o_msg_ack === 1'b1)      n_ack++;
      if (o_pattern_done === 1'b1) n_done++;
      if (o_ser_valid === 1'b1 && i_ser_ready && !i_rst) begin
         n_acc++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_word actual=%h expected=none", o_ser_data);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if (o_ser_data !== e) begin
               failures++;
               $display("FAIL stream_word actual=%h expected=%h", o_ser_data, e);
            end
         end
      end
      prev_hold = (o_ser_valid === 1'b1) && !i_ser_ready && !i_rst && !allow_drop;
      prev_data = o_ser_data;
   end

   task automatic wait_gap();
      int n;
      n = 0;
      while (o_busy === 1'b1 && n < 1000) begin
         n++;
         tick();
      end
      chk("gap_busy_cycles", 64'(n), 64'(GC));
   endtask

   // Burst with stop pulsed during word stop_at: words before it are uncounted, then PI counted.
   task automatic run_pattern(input int stop_at, output int words);
      int a0, d0, n;
      n  = (stop_at - 1) + PI;
      a0 = n_acc;
      d0 = n_done;
      for (int k = 0; k < n; k++) exp_q.push_back(64'hAAAA_AAAA_AAAA_AAAA);
      i_start_pattern_req = 1'b1;
      tick();
      i_start_pattern_req = 1'b0;
      for (int k = 1; k <= n; k++) begin
         i_pattern_stop = (k == stop_at);
         tick();
      end
      i_pattern_stop = 1'b0;
      chk("pattern_done_pulse", 64'(o_pattern_done), 64'd1);
      chk("pattern_gap_valid", 64'(o_ser_valid), 64'd0);
      wait_gap();
      words = n_acc - a0;
      chk("pattern_word_count", 64'(words), 64'(n));
      chk("pattern_done_once", 64'(n_done - d0), 64'd1);
   endtask

   task automatic send_msg(logic [63:0] h, logic [63:0] d, logic hd, logic [2:0] st);
      i_state = st; i_header = h; i_data = d; i_has_data = hd;
      i_msg_valid = 1'b1;
      tick();
      i_msg_valid = 1'b0;
      chk("ack_with_header", 64'(o_msg_ack), 64'd1);
      chk("hdr_valid", 64'(o_ser_valid), 64'd1);
      chk("hdr_word", o_ser_data, exp_hdr(h, d, hd));
   endtask

   initial begin
      int words, a0, k0;
      logic [63:0] hw;
      i_rst = 1'b1; i_state = 3'd0; i_start_pattern_req = 1'b0; i_pattern_stop = 1'b0;
      i_msg_valid = 1'b0; i_header = '0; i_has_data = 1'b0; i_data = '0; i_ser_ready = 1'b0;
      tick(); tick();
      chk("rst_valid", 64'(o_ser_valid), 64'd0);
      chk("rst_data", o_ser_data, 64'd0);
      chk("rst_ack_done_busy", 64'({o_msg_ack, o_pattern_done, o_busy}), 64'd0);
      i_rst = 1'b0;
      tick();

      // Pattern burst, stop during the 4th word: 3 + 4 words
      i_ser_ready = 1'b1;
      run_pattern(4, words);
      chk("pattern_words_literal", 64'(words), 64'd7);

      // No-data message
      i_ser_ready = 1'b0;
      exp_q.push_back(exp_hdr(64'h0000_0000_0048_0012, 64'h0, 1'b0));
      send_msg(64'h0000_0000_0048_0012, 64'h0, 1'b0, 3'd3);
      chk("nodata_hdr_literal", o_ser_data, 64'h0000_0000_0048_0012);
      chk("nodata_rx_parity", 64'(^o_ser_data[62:0]), 64'd0);
      i_ser_ready = 1'b1;
      tick();
      chk("nodata_gap_entry", 64'({o_ser_valid, o_msg_ack, o_busy}), 64'b001);
      wait_gap();

      // Message with data, ready held high: back-to-back header then data
      exp_q.push_back(exp_hdr(64'h0000_0000_0000_001B, 64'h1, 1'b1));
      exp_q.push_back(64'h1);
      send_msg(64'h0000_0000_0000_001B, 64'h1, 1'b1, 3'd3);
      chk("data_hdr_literal", o_ser_data, PAR_EN ? 64'h8000_0000_0000_001B : 64'h0000_0000_0000_001B);
      hw = o_ser_data;
      tick();
      chk("data_word", o_ser_data, 64'h1);
      chk("data_valid_ack", 64'({o_ser_valid, o_msg_ack}), 64'b10);
      chk("data_rx_parity", 64'(^{o_ser_data, hw[63]}), PAR_EN ? 64'd0 : 64'd1);
      tick();
      chk("data_gap_valid", 64'(o_ser_valid), 64'd0);
      wait_gap();

      // Backpressure: 10 cycles of ready low in HDR
      i_ser_ready = 1'b0;
      exp_q.push_back(exp_hdr(64'h0123_4567_89AB_CDEF, 64'h0, 1'b0));
      send_msg(64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 3'd5);
      a0 = n_acc;
      repeat (10) tick();
      chk("bp_still_valid", 64'(o_ser_valid), 64'd1);
      chk("bp_held_word", o_ser_data, exp_hdr(64'h0123_4567_89AB_CDEF, 64'h0, 1'b0));
      i_ser_ready = 1'b1;
      tick();
      chk("bp_accepted_once", 64'(n_acc - a0), 64'd1);
      chk("bp_gap_valid", 64'(o_ser_valid), 64'd0);
      wait_gap();

      // Abort in DATA with ready low
      k0 = n_ack;
      exp_q.push_back(exp_hdr(64'h0000_0000_0005_001B, 64'hDEAD_BEEF_0000_0001, 1'b1));
      send_msg(64'h0000_0000_0005_001B, 64'hDEAD_BEEF_0000_0001, 1'b1, 3'd2);
      tick();
      chk("abort_data_present", o_ser_data, 64'hDEAD_BEEF_0000_0001);
      i_ser_ready = 1'b0; i_state = 3'd0; allow_drop = 1'b1;
      tick();
      chk("abort_idle", 64'({o_ser_valid, o_busy}), 64'd0);
      chk("abort_data_zero", o_ser_data, 64'd0);
      allow_drop = 1'b0;
      i_ser_ready = 1'b1;
      a0 = n_acc;
      repeat (5) tick();
      chk("abort_no_more_words", 64'(n_acc - a0), 64'd0);
      chk("abort_single_ack", 64'(n_ack - k0), 64'd1);

      // Reset mid-pattern, then a full restart
      for (int k = 0; k < 7; k++) exp_q.push_back(64'hAAAA_AAAA_AAAA_AAAA);
      i_start_pattern_req = 1'b1;
      tick();
      i_start_pattern_req = 1'b0;
      i_pattern_stop = 1'b1;
      tick();
      i_pattern_stop = 1'b0;
      tick();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      chk("midrst_outputs", 64'({o_ser_valid, o_msg_ack, o_pattern_done, o_busy}), 64'd0);
      chk("midrst_data", o_ser_data, 64'd0);
      exp_q.delete();
      tick();
      run_pattern(3, words);
      chk("restart_words_literal", 64'(words), 64'd6);

      chk("stream_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
